// File: rtl/serial_add_ctrl_if.sv
// Handshake/result bundle for serial_add_ctrl.
// The sub port exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, s, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, s, cout);
`else
  modport master (output start, a, b, cin, input busy, done, s, cout);
  modport slave  (input start, a, b, cin, output busy, done, s, cout);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder Slice reused over WIDTH clocks, LSB first.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
module Slice (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);
  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  serial_add_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_pSum;
  logic [WIDTH-1:0] r_s;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             w_load;
  logic             w_last;
  logic             w_sliceS;
  logic             w_sliceCout;
  logic [WIDTH-1:0] w_bLoad;
  logic             w_carryLoad;

  Slice u_slice (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .o_s    (w_sliceS),
    .o_cout (w_sliceCout)
  );

  assign w_load = ((r_state == IDLE) || (r_state == DONE)) && bus.start;
  assign w_last = (r_state == RUN) && (r_cnt == LAST);

  // Subtraction is a + ~b + 1, so only the load values differ.
`ifdef SERIAL_ADD_SUB_EN
  assign w_bLoad     = bus.sub ? ~bus.b : bus.b;
  assign w_carryLoad = bus.sub ? 1'b1 : bus.cin;
`else
  assign w_bLoad     = bus.b;
  assign w_carryLoad = bus.cin;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = bus.start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Result registers update only on the final bit step and hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_pSum  <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
    end else if (w_load) begin
      r_a     <= bus.a;
      r_b     <= w_bLoad;
      r_pSum  <= '0;
      r_cnt   <= '0;
      r_carry <= w_carryLoad;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_pSum  <= {w_sliceS, r_pSum[WIDTH-1:1]};
      r_carry <= w_sliceCout;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_s    <= {w_sliceS, r_pSum[WIDTH-1:1]};
        r_cout <= w_sliceCout;
      end
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
  assign bus.s    = r_s;
  assign bus.cout = r_cout;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8).
// Subtract cases are included when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  serial_add_ctrl_if #(.WIDTH(8)) bus ();

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.s !== 8'h00 || bus.cout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: busy=%b done=%b s=%h cout=%b, required 0 0 00 0",
               bus.busy, bus.done, bus.s, bus.cout);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_add_carry_out;
    bus.a = 8'hFF; bus.b = 8'h01; bus.cin = 1'b0; bus.start = 1'b1;
    tick;
    bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL add_busy cycle %0d: busy=%b done=%b, required busy=1 done=0",
                 cyc, bus.busy, bus.done);
      end
      tick;
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.s !== 8'h00 || bus.cout !== 1'b1) begin
      errors++;
      $display("[TB] FAIL add_done cycle 9: done=%b busy=%b s=%h cout=%b, required 1 0 00 1",
               bus.done, bus.busy, bus.s, bus.cout);
    end
    for (int cyc = 10; cyc <= 12; cyc++) begin
      tick;
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.s !== 8'h00 || bus.cout !== 1'b1) begin
        errors++;
        $display("[TB] FAIL add_hold cycle %0d: done=%b busy=%b s=%h cout=%b, required 0 0 00 1",
                 cyc, bus.done, bus.busy, bus.s, bus.cout);
      end
    end
  endtask

  task automatic test_start_ignored;
    int doneCount;
    int doneCyc;
    logic [7:0] gotS;
    logic gotCout;
    doneCount = 0; doneCyc = -1; gotS = 8'hXX; gotCout = 1'bx;
    bus.a = 8'h5A; bus.b = 8'h33; bus.cin = 1'b1; bus.start = 1'b1;
    tick;
    bus.start = 1'b0; bus.a = 8'hC3; bus.b = 8'h77; bus.cin = 1'b0;
    checks++;
    if (bus.s !== 8'h00 || bus.cout !== 1'b1) begin
      errors++;
      $display("[TB] FAIL prev_result_hold: s=%h cout=%b, required 00 1", bus.s, bus.cout);
    end
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (bus.done === 1'b1) begin
        doneCount++;
        doneCyc = cyc;
        gotS = bus.s;
        gotCout = bus.cout;
      end
      bus.start = (cyc == 3);
      tick;
    end
    bus.start = 1'b0;
    checks++;
    if (doneCount != 1 || doneCyc != 9) begin
      errors++;
      $display("[TB] FAIL ignored_start_done: count=%0d cycle=%0d, required count=1 cycle=9",
               doneCount, doneCyc);
    end
    checks++;
    if (gotS !== 8'h8E || gotCout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_cin_result: s=%h cout=%b, required 8e 0", gotS, gotCout);
    end
  endtask

  task automatic test_back_to_back;
    logic expDone;
    logic expBusy;
    bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0; bus.start = 1'b1;
    tick;
    bus.a = 8'h80; bus.b = 8'h80;
    for (int cyc = 1; cyc <= 19; cyc++) begin
      expDone = (cyc == 9) || (cyc == 18);
      expBusy = (cyc >= 1 && cyc <= 8) || (cyc >= 10 && cyc <= 17);
      checks++;
      if (bus.done !== expDone || bus.busy !== expBusy) begin
        errors++;
        $display("[TB] FAIL b2b_flags cycle %0d: done=%b busy=%b, required done=%b busy=%b",
                 cyc, bus.done, bus.busy, expDone, expBusy);
      end
      if (cyc == 9) begin
        checks++;
        if (bus.s !== 8'h30 || bus.cout !== 1'b0) begin
          errors++;
          $display("[TB] FAIL b2b_first: s=%h cout=%b, required 30 0", bus.s, bus.cout);
        end
      end
      if (cyc == 18) begin
        checks++;
        if (bus.s !== 8'h00 || bus.cout !== 1'b1) begin
          errors++;
          $display("[TB] FAIL b2b_second: s=%h cout=%b, required 00 1", bus.s, bus.cout);
        end
      end
      if (cyc == 10) bus.start = 1'b0;
      tick;
    end
  endtask

  task automatic test_reset_mid_run;
    int doneCount;
    doneCount = 0;
    bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b0; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    tick;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.s !== 8'h00 || bus.cout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_run_reset: busy=%b done=%b s=%h cout=%b, required 0 0 00 0",
               bus.busy, bus.done, bus.s, bus.cout);
    end
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) doneCount++;
      tick;
    end
    checks++;
    if (doneCount != 0) begin
      errors++;
      $display("[TB] FAIL reset_no_done: active cycles=%0d, required 0", doneCount);
    end
    bus.a = 8'h01; bus.b = 8'h01; bus.cin = 1'b0; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int cyc = 1; cyc < 9; cyc++) tick;
    checks++;
    if (bus.done !== 1'b1 || bus.s !== 8'h02 || bus.cout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL after_reset_add: done=%b s=%h cout=%b, required 1 02 0",
               bus.done, bus.s, bus.cout);
    end
    tick;
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub;
    bus.sub = 1'b1; bus.a = 8'h05; bus.b = 8'h07; bus.cin = 1'b0; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int cyc = 1; cyc < 9; cyc++) tick;
    checks++;
    if (bus.done !== 1'b1 || bus.s !== 8'hFE || bus.cout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sub_borrow: done=%b s=%h cout=%b, required 1 fe 0",
               bus.done, bus.s, bus.cout);
    end
    bus.a = 8'h07; bus.b = 8'h05; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int cyc = 1; cyc < 9; cyc++) tick;
    checks++;
    if (bus.done !== 1'b1 || bus.s !== 8'h02 || bus.cout !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sub_no_borrow: done=%b s=%h cout=%b, required 1 02 1",
               bus.done, bus.s, bus.cout);
    end
    bus.sub = 1'b0;
    tick;
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = 1'b0;
`endif
    test_reset;
    test_add_carry_out;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid_run;
`ifdef SERIAL_ADD_SUB_EN
    test_sub;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
